// File: rtl/moxie_wb_ram_pkg.sv
// Shared types and bus widths for the Wishbone RAM slave.
// The package is named moxie_wb_pkg and is imported by the interface, the
// storage array and the top-level FSM.
package moxie_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;
  localparam int WB_SEL_W  = 4;

  // Transfer sequencing states: waiting for a strobe, burning wait states,
  // and the single acknowledge cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/moxie_wb_ram_if.sv
// Wishbone classic bus bundle between a master and moxie_wb_ram.
// The error acknowledge line exists only when MOXIE_WB_RAM_ERR_EN is defined.
interface moxie_wb_ram_if;
  import moxie_wb_pkg::*;

  logic [WB_ADDR_W-1:0] wb_adr_i;
  logic [WB_DATA_W-1:0] wb_dat_i;
  logic [WB_DATA_W-1:0] wb_dat_o;
  logic [WB_SEL_W-1:0]  wb_sel_i;
  logic                 wb_we_i;
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic                 wb_ack_o;
`ifdef MOXIE_WB_RAM_ERR_EN
  logic                 wb_err_o;
`endif

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
`ifdef MOXIE_WB_RAM_ERR_EN
    , input wb_err_o
`endif
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
`ifdef MOXIE_WB_RAM_ERR_EN
    , output wb_err_o
`endif
  );

endinterface

// File: rtl/moxie_wb_ram_array.sv
// Synchronous single-port 32-bit RAM with per-byte write enables.
// The read port register is cleared by reset so the bus read data starts at
// zero; the storage itself is never initialised or reset.
module moxie_wb_ram_array
  import moxie_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en,
  input  logic                  we,
  input  logic [WB_SEL_W-1:0]   sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WB_DATA_W-1:0]  wdata,
  output logic [WB_DATA_W-1:0]  rdata
);

  logic [WB_DATA_W-1:0] mem [2**ADDR_WIDTH];

  // Byte-lane write: only lanes with their sel bit set are updated.
  always_ff @(posedge clk_i) begin
    if (en && we) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (sel[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register only moves on a completed read, so it holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/moxie_wb_ram.sv
// Wishbone classic RAM slave with a programmable number of wait states.
// A request is captured in IDLE, optionally held in WAIT for WAIT_STATES
// cycles (dropping cyc/stb there aborts it), then acknowledged for exactly
// one cycle in ACK. The RAM is read or written on the edge entering ACK.
// Optional feature: define MOXIE_WB_RAM_ERR_EN to flag out-of-range or
// misaligned addresses with wb_err_o instead of wb_ack_o.
module moxie_wb_ram
  import moxie_wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  moxie_wb_ram_if.slave  wb
);

  localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  wb_state_e            state;
  logic [2:0]           wait_cnt;
  logic [WB_ADDR_W-1:0] adr_q;
  logic [WB_DATA_W-1:0] dat_q;
  logic [WB_SEL_W-1:0]  sel_q;
  logic                 we_q;
  logic                 ack_q;
`ifdef MOXIE_WB_RAM_ERR_EN
  logic                 err_q;
`endif

  logic                 req;
  logic                 enter_ack;
  logic                 addr_bad;
  logic [WB_ADDR_W-1:0] acc_adr;
  logic [WB_DATA_W-1:0] acc_dat;
  logic [WB_SEL_W-1:0]  acc_sel;
  logic                 acc_we;
  logic                 ram_en;
  logic [WB_DATA_W-1:0] ram_rdata;
  logic                 unused_adr;

  assign req = wb.wb_cyc_i & wb.wb_stb_i;

  // Access operands: straight from the bus when a zero-wait transfer commits
  // on its capture edge, otherwise from the values captured in IDLE.
  always_comb begin
    acc_adr = adr_q;
    acc_dat = dat_q;
    acc_sel = sel_q;
    acc_we  = we_q;
    if (state == IDLE) begin
      acc_adr = wb.wb_adr_i;
      acc_dat = wb.wb_dat_i;
      acc_sel = wb.wb_sel_i;
      acc_we  = wb.wb_we_i;
    end
  end

  // Detect the edge that moves the FSM into ACK; reset on that edge cancels it.
  always_comb begin
    enter_ack = 1'b0;
    if (!rst_i && req) begin
      if (state == IDLE && WAIT_STATES == 0) begin
        enter_ack = 1'b1;
      end else if (state == WAIT && wait_cnt == 3'd0) begin
        enter_ack = 1'b1;
      end
    end
  end

  // Address legality: with the error feature, any bit above the RAM or a
  // non-word-aligned address is rejected; otherwise those bits simply alias.
  always_comb begin
`ifdef MOXIE_WB_RAM_ERR_EN
    addr_bad = ((acc_adr >> (ADDR_WIDTH + 2)) != '0) || (acc_adr[1:0] != 2'b00);
`else
    addr_bad = 1'b0;
`endif
  end

  assign ram_en     = enter_ack && !addr_bad;
  assign unused_adr = ^{acc_adr[1:0], acc_adr[WB_ADDR_W-1:ADDR_WIDTH+2]};

  moxie_wb_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (ram_en),
    .we    (acc_we),
    .sel   (acc_sel),
    .addr  (acc_adr[ADDR_WIDTH+1:2]),
    .wdata (acc_dat),
    .rdata (ram_rdata)
  );

  // Transfer sequencer with registered acknowledge outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
`ifdef MOXIE_WB_RAM_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef MOXIE_WB_RAM_ERR_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            adr_q <= wb.wb_adr_i;
            dat_q <= wb.wb_dat_i;
            sel_q <= wb.wb_sel_i;
            we_q  <= wb.wb_we_i;
            if (WAIT_STATES > 0) begin
              state    <= WAIT;
              wait_cnt <= CNT_LOAD;
            end else begin
              state <= ACK;
              ack_q <= !addr_bad;
`ifdef MOXIE_WB_RAM_ERR_EN
              err_q <= addr_bad;
`endif
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
          end else if (wait_cnt == 3'd0) begin
            state <= ACK;
            ack_q <= !addr_bad;
`ifdef MOXIE_WB_RAM_ERR_EN
            err_q <= addr_bad;
`endif
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = ram_rdata;
`ifdef MOXIE_WB_RAM_ERR_EN
  assign wb.wb_err_o = err_q;
`endif

endmodule

// File: tb/tb_moxie_wb_ram.sv
// Self-checking bench for moxie_wb_ram: directed scenarios plus randomized
// transfers compared against a word-array reference model.
module tb_moxie_wb_ram;

  localparam int WS = 3;
  localparam int AW = 12;

  logic clk;
  logic rst;

  moxie_wb_ram_if wb ();

  moxie_wb_ram #(
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [2**AW];
  logic [31:0] lastRead;
  int          assertCount = 0;
  int          failCount   = 0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic isBad(input logic [31:0] a);
`ifdef MOXIE_WB_RAM_ERR_EN
    return ((a >> (AW + 2)) != 0) || ((a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int wordOf(input logic [31:0] a);
    return int'((a / 4) % (2**AW));
  endfunction

  function automatic logic doneSeen();
    logic d;
    d = wb.wb_ack_o;
`ifdef MOXIE_WB_RAM_ERR_EN
    d = d | wb.wb_err_o;
`endif
    return d;
  endfunction

  task automatic idleBus();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'h0;
    wb.wb_adr_i = 32'h0;
    wb.wb_dat_i = 32'h0;
  endtask

  // One complete transfer, entered and left at 1 ns after a rising edge.
  task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic we);
    int   n;
    int   idx;
    logic bad;
    bad = isBad(adr);
    idx = wordOf(adr);
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
    wb.wb_we_i  = we;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!doneSeen() && n < WS + 10);
    idleBus();
    // A master can change its inputs once the transfer is captured.
    wb.wb_dat_i = ~dat;
    checkOutput("latency", 32'(n), 32'(WS + 1));
    checkOutput("ack", {31'b0, wb.wb_ack_o}, {31'b0, !bad});
`ifdef MOXIE_WB_RAM_ERR_EN
    checkOutput("err", {31'b0, wb.wb_err_o}, {31'b0, bad});
`endif
    if (!bad) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) model[idx][8*b +: 8] = dat[8*b +: 8];
        end
      end else begin
        lastRead = model[idx];
      end
    end
    checkOutput("rdata", wb.wb_dat_o, lastRead);
    @(posedge clk);
    #1;
    checkOutput("ackPulse", {31'b0, doneSeen()}, 32'h0);
    wb.wb_dat_i = 32'h0;
  endtask

  // Watchdog so a wedged DUT still ends the run.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   acks;
    int   cyc;
    int   lastAck;
    logic sawAck;
    logic [31:0] adr;
    logic [31:0] beforeVal;

    idleBus();
    lastRead = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetAck", {31'b0, doneSeen()}, 32'h0);
    checkOutput("resetDat", wb.wb_dat_o, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Give every word the bench touches a known value.
    for (int w = 0; w < 32; w++) begin
      applyStimulus(32'(w * 4), $urandom, 4'hF, 1'b1);
    end

    $display("[TB] directed: write then read 0x10");
    applyStimulus(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    applyStimulus(32'h10, 32'h0, 4'hF, 1'b0);
    checkOutput("deadbeef", wb.wb_dat_o, 32'hDEADBEEF);

    $display("[TB] directed: byte lanes at 0x20");
    applyStimulus(32'h20, 32'h11223344, 4'hF, 1'b1);
    applyStimulus(32'h20, 32'hAABBCCDD, 4'b0101, 1'b1);
    applyStimulus(32'h24, 32'hFFFFFFFF, 4'h0, 1'b1);
    applyStimulus(32'h20, 32'h0, 4'hF, 1'b0);
    checkOutput("byteLanes", wb.wb_dat_o, 32'h11BB33DD);

    $display("[TB] directed: abort during second wait cycle");
    beforeVal = model[wordOf(32'h30)];
    wb.wb_adr_i = 32'h30;
    wb.wb_dat_i = 32'h55;
    wb.wb_sel_i = 4'hF;
    wb.wb_we_i  = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wb.wb_stb_i = 1'b0;
    sawAck = 1'b0;
    for (int i = 0; i < WS + 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) wb.wb_cyc_i = 1'b0;
      sawAck = sawAck | doneSeen();
    end
    idleBus();
    checkOutput("abortNoAck", {31'b0, sawAck}, 32'h0);
    applyStimulus(32'h30, 32'h0, 4'hF, 1'b0);
    checkOutput("abortNoWrite", wb.wb_dat_o, beforeVal);

    $display("[TB] directed: reset on the would-be commit edge");
    beforeVal = model[wordOf(32'h40)];
    wb.wb_adr_i = 32'h40;
    wb.wb_dat_i = 32'hCAFEF00D;
    wb.wb_sel_i = 4'hF;
    wb.wb_we_i  = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    repeat (WS) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstAck", {31'b0, doneSeen()}, 32'h0);
    checkOutput("rstDat", wb.wb_dat_o, 32'h0);
    rst = 1'b0;
    idleBus();
    lastRead = 32'h0;
    @(posedge clk);
    #1;
    checkOutput("rstAckAfter", {31'b0, doneSeen()}, 32'h0);
    applyStimulus(32'h40, 32'h0, 4'hF, 1'b0);
    checkOutput("rstNoWrite", wb.wb_dat_o, beforeVal);

    $display("[TB] directed: high address bits");
    applyStimulus(32'h0001_0000, 32'h0, 4'hF, 1'b0);

    $display("[TB] directed: back-to-back reads with strobe held");
    wb.wb_adr_i = 32'h14;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    acks    = 0;
    lastAck = 0;
    cyc     = 0;
    while (acks < 4 && cyc < 4 * (WS + 2) + 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wb.wb_ack_o) begin
        acks++;
        if (acks == 1) checkOutput("b2bFirst", 32'(cyc), 32'(WS + 1));
        else           checkOutput("b2bGap", 32'(cyc - lastAck), 32'(WS + 2));
        checkOutput("b2bData", wb.wb_dat_o, model[5]);
        lastAck = cyc;
        if (acks == 4) idleBus();
      end
    end
    idleBus();
    lastRead = model[5];
    checkOutput("b2bAcks", 32'(acks), 32'd4);
    sawAck = 1'b0;
    repeat (WS + 3) begin
      @(posedge clk);
      #1;
      sawAck = sawAck | doneSeen();
    end
    checkOutput("b2bNoExtra", {31'b0, sawAck}, 32'h0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 80; t++) begin
      adr = 32'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 3) == 0) adr = adr | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) adr = adr | (32'h1 << $urandom_range(AW + 2, 31));
      applyStimulus(adr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    for (int w = 0; w < 32; w++) begin
      applyStimulus(32'(w * 4), 32'h0, 4'hF, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/moxie_wb_ram.md
MOXIE_WB_RAM -- requirements
Module: moxie_wb_ram

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 12, word-address width (4096 x 32-bit words).
REQ-002 SHALL provide parameter WAIT_STATES, default 1, legal range 0..7, extra cycles inserted before acknowledge.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  clock; all state changes on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 wb_adr_i  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word.
REQ-007 wb_dat_i  input  32  write data.
REQ-008 wb_dat_o  output  32  read data.
REQ-009 wb_sel_i  input  4  byte-lane enables; bit n enables byte [8n+7:8n].
REQ-010 wb_we_i  input  1  1 = write, 0 = read.
REQ-011 wb_cyc_i  input  1  bus cycle in progress.
REQ-012 wb_stb_i  input  1  transfer strobe.
REQ-013 wb_ack_o  output  1  transfer acknowledge, registered.
REQ-014 wb_err_o  output  1  error acknowledge, present only with MOXIE_WB_RAM_ERR_EN.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-016 IDLE: on edge with wb_cyc_i & wb_stb_i, SHALL capture adr/dat/sel/we and go to WAIT when WAIT_STATES>0 (counter loaded WAIT_STATES-1), else to ACK.
REQ-017 WAIT: SHALL decrement counter each edge; at counter 0 go to ACK.
REQ-018 WAIT: if wb_cyc_i or wb_stb_i is low on an edge, SHALL abort to IDLE with no write and no acknowledge.
REQ-019 wb_ack_o SHALL be high exactly one cycle, the ACK-state cycle; ACK SHALL always return to IDLE on the next edge.
REQ-020 Latency: ack high WAIT_STATES+1 cycles after the edge sampling the strobe; back-to-back transfers cost WAIT_STATES+2 cycles each.
REQ-021 Write SHALL commit on the edge entering ACK, using the captured data, captured sel; unselected bytes unchanged; wb_sel_i=0 writes nothing but still acks.
REQ-022 Read data SHALL be loaded into wb_dat_o on the edge entering ACK and held until the next read completes.
REQ-023 Inputs changed by the master after the capture edge SHALL have no effect on the transfer in flight.
REQ-024 Memory contents SHALL be uninitialised and unaffected by reset.

Reset
REQ-025 On rst_i: state IDLE, counter 0, wb_ack_o 0, wb_err_o 0, wb_dat_o 32'h0.
REQ-026 Reset asserted in WAIT or ACK SHALL cancel the transfer; no write occurs if reset is sampled on the would-be commit edge.

Configuration
REQ-027 With MOXIE_WB_RAM_ERR_EN defined: address with any of bits [31:ADDR_WIDTH+2] set or bits [1:0] nonzero SHALL yield wb_err_o instead of wb_ack_o in the ACK cycle, no write, wb_dat_o unchanged.
REQ-028 Without MOXIE_WB_RAM_ERR_EN: no wb_err_o port; upper address bits ignored (aliasing), bits [1:0] ignored, every transfer acks.

Structure
REQ-029 Package moxie_wb_pkg SHALL hold the FSM state enum, WB_DATA_W=32, WB_ADDR_W=32, WB_SEL_W=4.
REQ-030 Storage SHALL be a sub-module moxie_wb_ram_array: synchronous single-port 32-bit RAM with per-byte write enables.

Verification
REQ-031 WAIT_STATES=1: write 0xDEADBEEF to 0x10 sel=4'hF, read 0x10 -> ack 2 cycles after strobe, dat_o=0xDEADBEEF.
REQ-032 Write 0x11223344 sel=4'hF to 0x20, then write 0xAABBCCDD sel=4'b0101 -> read 0x20 returns 0x11BB33DD.
REQ-033 WAIT_STATES=3: drop wb_stb_i in second WAIT cycle of a write 0x55 to 0x30 -> no ack; later read 0x30 returns prior value.
REQ-034 Assert rst_i in WAIT of a write -> ack stays 0, dat_o=0, target word unchanged; next transfer completes normally.
REQ-035 ERR_EN, ADDR_WIDTH=12: read 0x0001_0000 -> wb_err_o one cycle, wb_ack_o 0; without ERR_EN same access aliases to word 0 and acks.
REQ-036 WAIT_STATES=0, stb held high for 4 transfers -> ack every 2nd cycle, 4 acks total.
